rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16: maximum consecutive grant cycles per ownership, legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req, input, 4 bits: request per requester; bit i belongs to requester i; level-sensitive, held for the whole ownership.
REQ-005 The block SHALL have port gnt, output, 4 bits, registered: one-hot grant, or all-zero.
REQ-006 The block SHALL have port gnt_id, output, 2 bits, registered: index of the current or last owner.
REQ-007 The block SHALL have port busy, output, 1 bit, registered: high while any gnt bit is high.
REQ-008 The block SHALL have port timeout, output, 1 bit, registered: one-cycle pulse on a forced revoke.

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and GRANT (one owner).
REQ-010 In IDLE with req==0, the block SHALL stay in IDLE with gnt==0.
REQ-011 In IDLE with req!=0, the block SHALL select the first set bit searching from ptr upward, modulo 4.
REQ-012 On that selection, the block SHALL, at the same edge, set gnt to that bit, gnt_id to its index and busy to 1, and move to GRANT; request-to-grant latency is 1 cycle.
REQ-013 In GRANT, while req[gnt_id]==1 and no forced revoke applies, the block SHALL hold gnt unchanged; requests on other bits SHALL NOT preempt.
REQ-014 In GRANT, when req[gnt_id]==0 is sampled, the block SHALL clear gnt and busy at that edge and return to IDLE.
REQ-015 Every GRANT exit SHALL guarantee at least one IDLE cycle with gnt==0 before the next grant (no back-to-back handover).
REQ-016 On every GRANT exit, ptr SHALL be set to gnt_id+1 modulo 4 (3 wraps to 0), so the last owner has lowest priority.
REQ-017 gnt_id SHALL retain the last owner while in IDLE.
REQ-018 gnt SHALL never have more than one bit set.
REQ-019 busy SHALL equal the OR of gnt in every cycle.
REQ-020 When several bits of req assert in the same cycle, the block SHALL resolve them only by ptr order, per REQ-011.
REQ-021 When req changes during the IDLE gap cycle, the block SHALL use the value sampled at the IDLE edge.
REQ-022 The block SHALL maintain hold_cnt (8 bits): cleared on entry to GRANT and incremented each GRANT cycle; it SHALL saturate and SHALL NOT wrap.

Reset
REQ-023 When rst is low, the block SHALL asynchronously force state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0 and hold_cnt=0.
REQ-024 Reset asserted mid-ownership SHALL drop gnt immediately, without waiting for a clock edge.
REQ-025 After rst deasserts, the first arbitration SHALL occur on the first rising edge with req!=0.

Configuration
REQ-026 Macro RR_ARBITER4_TIMEOUT_EN SHALL control the forced-revoke feature.
REQ-027 With RR_ARBITER4_TIMEOUT_EN defined, in GRANT with hold_cnt==MAX_HOLD-1 and req[gnt_id] still 1, the block SHALL at the next edge clear gnt and busy, pulse timeout for exactly 1 cycle, go to IDLE and update ptr per REQ-016.
REQ-028 A revoked requester that keeps req high SHALL be re-granted only after the higher-priority requesters, per the rotated ptr.
REQ-029 Without RR_ARBITER4_TIMEOUT_EN, ownership SHALL be unbounded, timeout SHALL be tied to 0, hold_cnt MAY be omitted and MAX_HOLD SHALL be ignored.

Verification
REQ-030 The bench SHALL cover: after reset, req=4'b0100 for 1 cycle -> next cycle gnt=4'b0100, gnt_id=2, busy=1; when req drops, gnt=0 on the following edge.
REQ-031 The bench SHALL cover: reset, then req=4'b1111 held with each owner releasing after 3 cycles -> grant order 0,1,2,3,0 with one gnt==0 cycle between owners.
REQ-032 The bench SHALL cover: owner 3 releases while req=4'b1001 -> ptr wraps to 0, next gnt=4'b0001.
REQ-033 The bench SHALL cover: owner 1 is granted, then req[2] rises -> gnt stays 4'b0010 until req[1] drops, then gnt=4'b0100 after one IDLE cycle.
REQ-034 The bench SHALL cover: rst pulled low mid-clock during ownership -> gnt=0 and busy=0 before the next edge; after release with req=4'b1000 -> gnt=4'b1000.
REQ-035 The bench SHALL cover, with RR_ARBITER4_TIMEOUT_EN and MAX_HOLD=4: req=4'b0011 held constantly -> gnt=4'b0001 for 4 cycles, then timeout=1 for one cycle, gnt=0 for one cycle, then gnt=4'b0010; without the macro, gnt=4'b0001 persists and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with non-preemptive ownership and a mandatory idle gap.
// Optional forced revoke after MAX_HOLD grant cycles is enabled by RR_ARBITER4_TIMEOUT_EN.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic [1:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;
    logic [1:0] cand;
    logic [1:0] pick;
    logic       pick_vld;
    logic       revoke;

`ifdef RR_ARBITER4_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    assign revoke = (state_q == StGrant) && req[gnt_id_q] && (hold_cnt_q == 8'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = 8'd0;
        timeout_d  = revoke;
        if (state_q == StGrant) begin
            hold_cnt_d = (hold_cnt_q == 8'hff) ? hold_cnt_q : hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
    assign revoke          = 1'b0;
    assign timeout         = 1'b0;
`endif

    // Descending scan so the candidate closest to ptr is the last one written.
    always_comb begin
        cand     = 2'd0;
        pick     = 2'd0;
        pick_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        case (state_q)
            StIdle: begin
                gnt_d  = 4'b0000;
                busy_d = 1'b0;
                if (pick_vld) begin
                    state_d  = StGrant;
                    gnt_d    = 4'b0001 << pick;
                    gnt_id_d = pick;
                    busy_d   = 1'b1;
                end
            end
            StGrant: begin
                // Exit always lands in IDLE, which forces the one-cycle gap.
                if (!req[gnt_id_q] || revoke) begin
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    ptr_d   = gnt_id_q + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            busy_q   <= 1'b0;
            ptr_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: vector table plus hand-written multi-cycle sequences.
// Expectations for the revoke sequence follow RR_ARBITER4_TIMEOUT_EN.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb, input logic et);
        n_checks++;
        if ({gnt, gnt_id, busy, timeout} === {eg, eid, eb, et}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got gnt=%b id=%0d busy=%b timeout=%b, want gnt=%b id=%0d busy=%b timeout=%b",
                     name, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
        end
    endtask

    // Apply req ahead of the next rising edge, sample 1 time unit after it.
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b0;
        #1;
        check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[2]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[3]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[4]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        vecs[5]  = '{4'b0001, 4'b0000, 2'd3, 1'b0};
        vecs[6]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[8]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
        vecs[9]  = '{4'b0110, 4'b0010, 2'd1, 1'b1};
        vecs[10] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
        vecs[11] = '{4'b0100, 4'b0000, 2'd1, 1'b0};
        vecs[12] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[13] = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[14] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[15] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[16] = '{4'b1101, 4'b0100, 2'd2, 1'b1};
        vecs[17] = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[18] = '{4'b0111, 4'b0001, 2'd0, 1'b1};
        vecs[19] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

        rst = 1'b1;
        req = 4'b0000;
        do_reset();

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, 1'b0);
        end

        // All four requesting, each owner releases after 3 grant cycles.
        do_reset();
        begin
            int order[5] = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++) begin
                logic [3:0] bit_k;
                bit_k = 4'b0001 << order[k];
                for (int c = 0; c < 3; c++) begin
                    step(4'b1111);
                    check($sformatf("rr_own%0d_c%0d", k, c), bit_k, 2'(order[k]), 1'b1, 1'b0);
                end
                step(4'b1111 & ~bit_k);
                check($sformatf("rr_gap%0d", k), 4'b0000, 2'(order[k]), 1'b0, 1'b0);
            end
        end

        // Asynchronous reset during ownership.
        do_reset();
        step(4'b0010);
        check("pre_async_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(4'b1000);
        check("post_rst_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b0000);
        check("post_rst_release", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Ownership bound with req held constantly.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(4'b0011);
            check($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`ifdef RR_ARBITER4_TIMEOUT_EN
        step(4'b0011);
        check("revoke_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
        step(4'b0011);
        check("regrant_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0011);
        check("pulse_cleared", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        for (int c = 0; c < 4; c++) begin
            step(4'b0011);
            check($sformatf("unbounded_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
